// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame sizes and parity encodings
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int unsigned UART_DATA_BITS   = 8;
    localparam int unsigned FRAME_LEN_NOPAR  = 10;
    localparam int unsigned FRAME_LEN_PAR    = 11;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: even parity is the XOR of the payload,
// odd parity its inverse. Shared with the receiver's parity checker.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_BITS
) (
    input  logic [WIDTH-1:0] data,
    input  logic             par_typ,
    output logic             par_bit
);

    assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter: start bit, DATA_WIDTH bits LSB first, optional parity,
// one stop bit; each bit lasts the latched prescale (min 2) clocks.
module uart_tx_top
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = UART_DATA_BITS,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      DATA_VLD,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      TX_OUT,
    output logic                      BUSY
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    uart_state_t               state, state_next;
    logic [PRESCALE_WIDTH-1:0] timer, timer_next;
    logic [IDX_W-1:0]          idx, idx_next;

    logic [DATA_WIDTH-1:0]     data_q;
    logic                      par_en_q;
    logic                      par_q;
    logic [PRESCALE_WIDTH-1:0] ps_q;

    logic                      par_calc;
    logic [PRESCALE_WIDTH-1:0] ps_clamped;
    logic                      accept;
    logic                      bit_last;
    logic                      tx_next;
    logic                      busy_next;

    uart_parity_calc #(
        .WIDTH(DATA_WIDTH)
    ) u_parity (
        .data   (P_DATA),
        .par_typ(PAR_TYP),
        .par_bit(par_calc)
    );

    assign ps_clamped = (prescale < PRESCALE_WIDTH'(2)) ? PRESCALE_WIDTH'(2) : prescale;
    assign accept     = (state == ST_IDLE) && DATA_VLD;
    assign bit_last   = (timer == (ps_q - PRESCALE_WIDTH'(1)));

    // TX_OUT/BUSY are registered from the next-state decode, so the pin
    // changes on the same edge as the state and never sees a comb path.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            timer  <= '0;
            idx    <= '0;
            TX_OUT <= 1'b1;
            BUSY   <= 1'b0;
        end else begin
            state  <= state_next;
            timer  <= timer_next;
            idx    <= idx_next;
            TX_OUT <= tx_next;
            BUSY   <= busy_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && accept) begin
            data_q   <= P_DATA;
            par_en_q <= PAR_EN;
            par_q    <= par_calc;
            ps_q     <= ps_clamped;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        idx_next   = idx;
        case (state)
            ST_IDLE: begin
                timer_next = '0;
                idx_next   = '0;
                if (accept) state_next = ST_START;
            end
            default: begin
                if (bit_last) begin
                    timer_next = '0;
                    case (state)
                        ST_START:  state_next = ST_DATA;
                        ST_DATA: begin
                            if (idx == IDX_LAST) begin
                                idx_next   = '0;
                                state_next = par_en_q ? ST_PARITY : ST_STOP;
                            end else begin
                                idx_next = idx + IDX_W'(1);
                            end
                        end
                        ST_PARITY: state_next = ST_STOP;
                        default:   state_next = ST_IDLE;
                    endcase
                end else begin
                    timer_next = timer + PRESCALE_WIDTH'(1);
                end
            end
        endcase
    end

    always_comb begin
        busy_next = (state_next != ST_IDLE);
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = data_q[idx_next];
            ST_PARITY: tx_next = par_q;
            default:   tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_top.sv
// Bench for uart_tx_top: table of frames plus hand sequences; a monitor
// decodes TX_OUT cycle by cycle against a scoreboard queue of expected frames.
module tb_uart_tx_top;

    typedef struct {
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        logic [5:0]  ps;
        int unsigned ps_eff;
        logic        parity;
        int unsigned len;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VLD;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] prescale;
    logic       TX_OUT;
    logic       BUSY;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    int unsigned cyc      = 0;
    int unsigned mon_frames = 0;
    bit          mon_active = 1'b0;
    vec_t        sb_q[$];
    int unsigned start_q[$];

    uart_tx_top #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .P_DATA  (P_DATA),
        .DATA_VLD(DATA_VLD),
        .PAR_EN  (PAR_EN),
        .PAR_TYP (PAR_TYP),
        .prescale(prescale),
        .TX_OUT  (TX_OUT),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic exp_bit(input vec_t v, input int unsigned j);
        if (j == 0) return 1'b0;
        if (j <= 8) return v.data[j-1];
        if (v.par_en && j == 9) return v.parity;
        return 1'b1;
    endfunction

    // Monitor: a falling TX_OUT outside reset marks a start bit.
    initial begin : monitor
        vec_t        v;
        int unsigned bad, busy_n, j;
        logic [7:0]  rx;
        logic        rpar;
        bit          aborted;
        forever begin
            @(negedge CLK);
            if (RST === 1'b0 && TX_OUT === 1'b0) begin
                mon_frames++;
                start_q.push_back(cyc);
                if (sb_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    for (int k = 0; k < 1000 && TX_OUT !== 1'b1; k++) @(negedge CLK);
                end else begin
                    v = sb_q.pop_front();
                    mon_active = 1'b1;
                    aborted = 1'b0;
                    bad = 0; busy_n = 0; rx = '0; rpar = 1'b0;
                    for (int unsigned c = 0; c < v.len; c++) begin
                        if (c != 0) @(negedge CLK);
                        if (RST !== 1'b0) begin
                            aborted = 1'b1;
                            break;
                        end
                        j = c / v.ps_eff;
                        if (TX_OUT !== exp_bit(v, j)) bad++;
                        if (BUSY === 1'b1) busy_n++;
                        if (c % v.ps_eff == v.ps_eff / 2) begin
                            if (j >= 1 && j <= 8) rx[j-1] = TX_OUT;
                            if (j == 9) rpar = TX_OUT;
                        end
                    end
                    if (!aborted) begin
                        chk("rx_byte", rx, v.data);
                        if (v.par_en) chk("rx_parity", rpar, v.parity);
                        chk("frame_cycles_bad", bad, 0);
                        chk("busy_len", busy_n, v.len);
                        @(negedge CLK);
                        chk("frame_end_busy_tx", {BUSY, TX_OUT}, 2'b01);
                    end
                    mon_active = 1'b0;
                end
            end
        end
    end

    task automatic wait_not_busy(input int unsigned budget);
        int unsigned n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while ((BUSY !== 1'b0 || mon_active) && n < budget);
        chk("wait_idle_timeout", (n >= budget) ? 1 : 0, 0);
    endtask

    task automatic send(input vec_t v);
        wait_not_busy(2000);
        P_DATA   = v.data;
        PAR_EN   = v.par_en;
        PAR_TYP  = v.par_typ;
        prescale = v.ps;
        DATA_VLD = 1'b1;
        sb_q.push_back(v);
        @(posedge CLK);
        #1;
        DATA_VLD = 1'b0;
        P_DATA   = 8'($urandom);
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
        prescale = 6'($urandom);
        @(negedge CLK);
        chk("accept_latency_busy_tx", {BUSY, TX_OUT}, 2'b10);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        vec_t        tbl[7];
        vec_t        v1, v2;
        int unsigned f0, gap, n;

        tbl[0] = '{8'hAD, 1'b1, 1'b0, 6'd8,  8,  1'b1, 88};
        tbl[1] = '{8'h98, 1'b0, 1'b0, 6'd16, 16, 1'b0, 160};
        tbl[2] = '{8'h75, 1'b1, 1'b1, 6'd32, 32, 1'b0, 352};
        tbl[3] = '{8'h00, 1'b1, 1'b1, 6'd4,  4,  1'b1, 44};
        tbl[4] = '{8'hFF, 1'b1, 1'b0, 6'd3,  3,  1'b0, 33};
        tbl[5] = '{8'h5A, 1'b0, 1'b0, 6'd0,  2,  1'b0, 20};
        tbl[6] = '{8'hC3, 1'b1, 1'b1, 6'd1,  2,  1'b1, 22};

        RST = 1'b1; DATA_VLD = 1'b0; P_DATA = '0;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd8;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_tx", TX_OUT, 1'b1);
        chk("reset_busy", BUSY, 1'b0);
        @(posedge CLK);
        #1 RST = 1'b0;

        for (int i = 0; i < 7; i++) send(tbl[i]);
        wait_not_busy(2000);

        // Back-to-back with DATA_VLD held: next start one idle cycle after stop.
        v1 = '{8'hDE, 1'b0, 1'b0, 6'd8, 8, 1'b0, 80};
        v2 = '{8'h75, 1'b0, 1'b0, 6'd8, 8, 1'b0, 80};
        P_DATA = v1.data; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd8;
        DATA_VLD = 1'b1;
        sb_q.push_back(v1);
        @(posedge CLK);
        #1 P_DATA = v2.data;
        sb_q.push_back(v2);
        n = 0;
        do begin @(negedge CLK); n++; end while (BUSY !== 1'b0 && n < 200);
        @(posedge CLK);
        #1 DATA_VLD = 1'b0;
        wait_not_busy(2000);
        gap = (start_q.size() >= 2) ? start_q[start_q.size()-1] - start_q[start_q.size()-2] : 0;
        chk("b2b_start_gap", gap, 81);

        // Request while busy must be dropped.
        f0 = mon_frames;
        send('{8'h3C, 1'b0, 1'b0, 6'd8, 8, 1'b0, 80});
        repeat (30) @(negedge CLK);
        P_DATA = 8'hFF; DATA_VLD = 1'b1;
        @(negedge CLK);
        DATA_VLD = 1'b0;
        wait_not_busy(2000);
        repeat (40) @(negedge CLK);
        chk("ignored_req_frames", mon_frames - f0, 1);
        chk("ignored_req_idle", {BUSY, TX_OUT}, 2'b01);

        // One-cycle reset during data bit 3, with a request presented in reset.
        send('{8'hA5, 1'b0, 1'b0, 6'd8, 8, 1'b0, 80});
        repeat (34) @(posedge CLK);
        #1 RST = 1'b1; DATA_VLD = 1'b1; P_DATA = 8'h81;
        @(posedge CLK);
        #1 RST = 1'b0; DATA_VLD = 1'b0;
        @(negedge CLK);
        chk("rst_mid_busy_tx", {BUSY, TX_OUT}, 2'b01);
        repeat (20) @(negedge CLK);
        chk("rst_stays_idle", {BUSY, TX_OUT}, 2'b01);
        send('{8'h3C, 1'b1, 1'b0, 6'd8, 8, 1'b0, 88});
        wait_not_busy(2000);
        repeat (5) @(negedge CLK);

        chk("sb_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_top.md
# uart_tx_top

Parallel-to-serial UART transmitter, the upstream counterpart of `uart_rx_top`. It accepts one byte per handshake, frames it as start bit, 8 data bits LSB-first, optional parity and one stop bit, and drives `TX_OUT`. It runs on the same oversampled clock as the receiver (`prescale` clocks per bit), so a TX→RX loopback at 8/16/32 needs no extra clocking.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame.
- `PRESCALE_WIDTH`, default 6: width of `prescale`.
- `CLK`  in  1: single clock, rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `P_DATA`  in  DATA_WIDTH: byte to send.
- `DATA_VLD`  in  1: request; the byte is accepted on any rising edge where `DATA_VLD`=1 and `BUSY`=0.
- `PAR_EN`  in  1: 1 adds a parity bit.
- `PAR_TYP`  in  1: 0 = even, 1 = odd.
- `prescale`  in  PRESCALE_WIDTH: clocks per bit.
- `TX_OUT`  out  1: serial line, idle high, registered.
- `BUSY`  out  1: frame in progress, registered.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `TX_OUT`=1, `BUSY`=0.
  - On acceptance, latch `P_DATA`, `PAR_EN`, `PAR_TYP`, `prescale` and the computed parity into frame registers, then go to START.
- Input changes after acceptance have no effect on the current frame.
- Bit timer counts 0..ps-1, where ps is the latched prescale.
  - Latched value <2 is clamped to 2.
  - Each state holds exactly ps cycles.
- DATA:
  - 3-bit index 0..7 sends `data[index]` (LSB first).
  - After bit 7 → PARITY if parity is enabled, else STOP.
- Parity bit:
  - Even: XOR of the 8 bits.
  - Odd: inverted XOR.
- START drives 0, STOP drives 1. After STOP → IDLE.
- `DATA_VLD` while `BUSY`=1 is ignored; no queuing.
- Reset behaviour:
  - In any state, `RST`=1 forces IDLE on the next edge: `TX_OUT`=1, `BUSY`=0, timer and index cleared.
  - A frame interrupted by reset is truncated and is not resumed.
  - `DATA_VLD` is ignored during reset.
- Reset values: `TX_OUT`=1, `BUSY`=0.

## Timing
- Acceptance edge at cycle k: from cycle k+1, `TX_OUT`=0 (start bit) and `BUSY`=1.
- Frame length N·ps cycles, where N=11 with parity, else 10.
  - Bit j occupies cycles k+1+j·ps … k+(j+1)·ps.
- `BUSY` falls at the edge that ends the last stop cycle, so it is 0 from cycle k+N·ps+1.
- Back-to-back: `DATA_VLD` held high is accepted at the edge ending cycle k+N·ps+1. This gives exactly one idle-high cycle between frames.
- `TX_OUT` is glitch-free: it comes straight from a flop with no combinational path to the pin.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (common with the RX FSM encoding style).
  - `UART_DATA_BITS`=8.
  - Frame-length constants 10/11.
  - Parity type encodings `PAR_EVEN`=0, `PAR_ODD`=1.
- Sub-module `uart_parity_calc`:
  - Combinational; inputs data and `PAR_TYP`, output parity bit.
  - Reused by the RX parity checker.
- Top holds the FSM, bit timer, bit index and frame registers.

## Test plan
- ps=8, parity on, even, 0xAD:
  - `TX_OUT` over 88 cycles follows 0,1,0,1,1,0,1,0,1,1,1 (parity=1).
  - `BUSY` high for exactly 88 cycles.
- ps=16, parity off, 0x98 → 160-cycle frame 0,0,0,0,1,1,0,0,1,1. Loopback into `uart_rx_top` yields `P_DATA`=0x98 with `DATA_VLD` pulse and no errors.
- ps=32, parity on, odd, 0x75 (5 ones) → parity bit 0. RX loopback reports `PAR_ERR`=0 and `P_DATA`=0x75.
- Back-to-back: `DATA_VLD` held high with 0xDE then 0x75, ps=8, no parity. Require exactly one idle-high cycle between the frames and both bytes received in order.
- Ignored request: pulse `DATA_VLD` with 0xFF mid-frame → the current frame is unchanged and no second frame is sent.
- Reset mid-frame: assert `RST` for 1 cycle during data bit 3. Next cycle `TX_OUT`=1 and `BUSY`=0. A new request afterwards transmits correctly.
